// File: rtl/cpu_pkg.sv
// Shared CPU types and constants for the register-bank writeback path.
`ifndef NUM_REGS
`define NUM_REGS 32
`endif
`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif

package cpu_pkg;

  localparam int NUM_REGS_DEF  = `NUM_REGS;
  localparam int REG_WIDTH_DEF = `REG_WIDTH;
  localparam int RW_DEF        = $clog2(NUM_REGS_DEF);

  // Writeback sources: index 0 is ALU writeback, index 1 is memory-load writeback.
  localparam int NUM_WB_SRC = 2;

  typedef logic [RW_DEF-1:0]        reg_idx_t;
  typedef logic [REG_WIDTH_DEF-1:0] reg_data_t;

  typedef enum logic {
    WB_SRC_ALU = 1'b0,
    WB_SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/cpu_rr_arbiter2.sv
// Two-input round-robin arbiter. The last_grant flop remembers the most
// recent winner so that, under contention, the other input wins next.
module cpu_rr_arbiter2
  import cpu_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_WB_SRC-1:0] req_i,
  output logic [NUM_WB_SRC-1:0] gnt_o,
  output logic                  last_grant_o
);

  logic last_grant_q;
  logic last_grant_d;

  // Grant logic: a lone requester always wins; under contention the input
  // that did not win most recently is preferred.
  always_comb begin
    gnt_o        = '0;
    last_grant_d = last_grant_q;
    if (req_i[0] && req_i[1]) begin
      if (last_grant_q == WB_SRC_MEM) begin
        gnt_o[0] = 1'b1;
      end else begin
        gnt_o[1] = 1'b1;
      end
    end else if (req_i[0]) begin
      gnt_o[0] = 1'b1;
    end else if (req_i[1]) begin
      gnt_o[1] = 1'b1;
    end
    if (gnt_o[0]) begin
      last_grant_d = WB_SRC_ALU;
    end else if (gnt_o[1]) begin
      last_grant_d = WB_SRC_MEM;
    end
  end

  // Last-winner flop; resets to source 1 so source 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= WB_SRC_MEM;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign last_grant_o = last_grant_q;

endmodule

// File: rtl/cpu_bank_reg_wb_arbiter.sv
// Writeback controller for the CPU register bank: arbitrates the ALU and
// load writeback sources onto the single bank write port, registers the
// winning write, and keeps a per-register pending scoreboard for decode.
module cpu_bank_reg_wb_arbiter
  import cpu_pkg::*;
#(
  parameter int NUM_REGS  = `NUM_REGS,
  parameter int REG_WIDTH = `REG_WIDTH,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 issue_valid,
  input  logic [RW-1:0]        issue_reg,
  output logic                 issue_ready,
  input  logic                 src0_valid,
  input  logic [RW-1:0]        src0_reg,
  input  logic [REG_WIDTH-1:0] src0_data,
  output logic                 src0_ready,
  input  logic                 src1_valid,
  input  logic [RW-1:0]        src1_reg,
  input  logic [REG_WIDTH-1:0] src1_data,
  output logic                 src1_ready,
  input  logic [RW-1:0]        query_reg_a,
  input  logic [RW-1:0]        query_reg_b,
  output logic                 busy_a,
  output logic                 busy_b,
  output logic [RW-1:0]        write_reg,
  output logic [REG_WIDTH-1:0] write_data,
  output logic                 write_enable
);

  logic [NUM_WB_SRC-1:0] req;
  logic [NUM_WB_SRC-1:0] gnt;
  logic                  last_grant;

  logic                  commit_now;
  logic [RW-1:0]         commit_reg;
  logic [REG_WIDTH-1:0]  commit_data;
  logic                  issue_accept;

  logic [NUM_REGS-1:0]   pending_q;
  logic [NUM_REGS-1:0]   pending_d;
  logic [RW-1:0]         write_reg_q;
  logic [REG_WIDTH-1:0]  write_data_q;
  logic                  write_enable_q;

  assign req = {src1_valid, src0_valid};

  cpu_rr_arbiter2 u_arb (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req),
    .gnt_o        (gnt),
    .last_grant_o (last_grant)
  );

  assign src0_ready = gnt[0];
  assign src1_ready = gnt[1];

  // Select the winning write; the grant is one-hot so a simple mux suffices.
  always_comb begin
    commit_now  = |gnt;
    commit_reg  = src0_reg;
    commit_data = src0_data;
    if (gnt[1]) begin
      commit_reg  = src1_reg;
      commit_data = src1_data;
    end
  end

  // An issue may proceed when its destination is idle, or when the only
  // outstanding writer to it is committing right now (keeps one writer per reg).
  always_comb begin
    issue_ready  = !pending_q[issue_reg] || (commit_now && (commit_reg == issue_reg));
    issue_accept = issue_valid && issue_ready;
  end

  // Scoreboard next state: the clear is applied first so a same-cycle set wins.
  always_comb begin
    pending_d = pending_q;
    if (commit_now) begin
      pending_d[commit_reg] = 1'b0;
    end
    if (issue_accept) begin
      pending_d[issue_reg] = 1'b1;
    end
  end

  // Pending scoreboard flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Bank write-port register: load on grant, otherwise hold reg/data and drop enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_enable_q <= 1'b0;
      write_reg_q    <= '0;
      write_data_q   <= '0;
    end else begin
      write_enable_q <= commit_now;
      if (commit_now) begin
        write_reg_q  <= commit_reg;
        write_data_q <= commit_data;
      end
    end
  end

  assign busy_a       = pending_q[query_reg_a];
  assign busy_b       = pending_q[query_reg_b];
  assign write_reg    = write_reg_q;
  assign write_data   = write_data_q;
  assign write_enable = write_enable_q;

  logic unused_last_grant;
  assign unused_last_grant = last_grant;

endmodule

// File: tb/tb_cpu_bank_reg_wb_arbiter.sv
// Directed testbench for the register-bank writeback arbiter.
module tb_cpu_bank_reg_wb_arbiter;

  localparam int NREGS = 32;
  localparam int DW    = 32;
  localparam int RWB   = $clog2(NREGS);

  logic            clk;
  logic            rst_n;
  logic            issue_valid;
  logic [RWB-1:0]  issue_reg;
  logic            issue_ready;
  logic            src0_valid;
  logic [RWB-1:0]  src0_reg;
  logic [DW-1:0]   src0_data;
  logic            src0_ready;
  logic            src1_valid;
  logic [RWB-1:0]  src1_reg;
  logic [DW-1:0]   src1_data;
  logic            src1_ready;
  logic [RWB-1:0]  query_reg_a;
  logic [RWB-1:0]  query_reg_b;
  logic            busy_a;
  logic            busy_b;
  logic [RWB-1:0]  write_reg;
  logic [DW-1:0]   write_data;
  logic            write_enable;

  int checks = 0;
  int errors = 0;

  cpu_bank_reg_wb_arbiter #(.NUM_REGS(NREGS), .REG_WIDTH(DW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_reg    (issue_reg),
    .issue_ready  (issue_ready),
    .src0_valid   (src0_valid),
    .src0_reg     (src0_reg),
    .src0_data    (src0_data),
    .src0_ready   (src0_ready),
    .src1_valid   (src1_valid),
    .src1_reg     (src1_reg),
    .src1_data    (src1_data),
    .src1_ready   (src1_ready),
    .query_reg_a  (query_reg_a),
    .query_reg_b  (query_reg_b),
    .busy_a       (busy_a),
    .busy_b       (busy_b),
    .write_reg    (write_reg),
    .write_data   (write_data),
    .write_enable (write_enable)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge, where inputs are driven.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    issue_valid = 1'b0;
    issue_reg   = '0;
    src0_valid  = 1'b0;
    src0_reg    = '0;
    src0_data   = '0;
    src1_valid  = 1'b0;
    src1_reg    = '0;
    src1_data   = '0;
    query_reg_a = '0;
    query_reg_b = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    step();
    #1;
    checks++;
    if (write_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_we actual=%b required=0", write_enable);
    end
    checks++;
    if (write_reg !== '0 || write_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset_wport actual=%0d/%h required=0/0", write_reg, write_data);
    end
    for (int r = 0; r < NREGS; r++) begin
      query_reg_a = RWB'(r);
      query_reg_b = RWB'(NREGS - 1 - r);
      #1;
      checks++;
      if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_busy r%0d actual=%b%b required=00", r, busy_a, busy_b);
      end
    end
    step();
    rst_n = 1'b1;
    step();
    issue_valid = 1'b1;
    issue_reg   = 5;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_issue_ready actual=%b required=1", issue_ready);
    end
    step();
    issue_valid = 1'b0;
    query_reg_a = 5;
    #1;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_busy_r5 actual=%b required=1", busy_a);
    end
  endtask

  task automatic test_single_source();
    src0_valid = 1'b1;
    src0_reg   = 5;
    src0_data  = 32'h0000_A5A5;
    #1;
    checks++;
    if (src0_ready !== 1'b1 || src1_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_grant actual=%b%b required=01", src1_ready, src0_ready);
    end
    step();
    src0_valid  = 1'b0;
    query_reg_a = 5;
    #1;
    checks++;
    if (write_enable !== 1'b1 || write_reg !== 5 || write_data !== 32'h0000_A5A5) begin
      errors++;
      $display("[TB] FAIL single_write actual=%b/%0d/%h required=1/5/0000a5a5",
               write_enable, write_reg, write_data);
    end
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_busy_r5 actual=%b required=0", busy_a);
    end
  endtask

  task automatic test_contention();
    logic [RWB-1:0] s0r [4];
    logic [DW-1:0]  s0d [4];
    logic [RWB-1:0] s1r [4];
    logic [DW-1:0]  s1d [4];
    logic [1:0]     eg  [4];
    logic [RWB-1:0] er  [4];
    logic [DW-1:0]  ed  [4];
    s0r = '{1, 3, 3, 6};
    s0d = '{32'h11, 32'h33, 32'h33, 32'h66};
    s1r = '{2, 2, 4, 4};
    s1d = '{32'h22, 32'h22, 32'h44, 32'h44};
    eg  = '{2'b01, 2'b10, 2'b01, 2'b10};
    er  = '{1, 2, 3, 4};
    ed  = '{32'h11, 32'h22, 32'h33, 32'h44};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      src0_valid = 1'b1;
      src0_reg   = s0r[c];
      src0_data  = s0d[c];
      src1_valid = 1'b1;
      src1_reg   = s1r[c];
      src1_data  = s1d[c];
      #1;
      checks++;
      if ({src1_ready, src0_ready} !== eg[c]) begin
        errors++;
        $display("[TB] FAIL contention_grant c%0d actual=%b required=%b", c, {src1_ready, src0_ready}, eg[c]);
      end
      if (c > 0) begin
        checks++;
        if (write_enable !== 1'b1 || write_reg !== er[c-1] || write_data !== ed[c-1]) begin
          errors++;
          $display("[TB] FAIL contention_write c%0d actual=%b/%0d/%h required=1/%0d/%h",
                   c, write_enable, write_reg, write_data, er[c-1], ed[c-1]);
        end
      end
      step();
    end
    src0_valid = 1'b0;
    src1_valid = 1'b0;
    #1;
    checks++;
    if (write_enable !== 1'b1 || write_reg !== 4 || write_data !== 32'h44) begin
      errors++;
      $display("[TB] FAIL contention_last_write actual=%b/%0d/%h required=1/4/44", write_enable, write_reg, write_data);
    end
    step();
    checks++;
    if (write_enable !== 1'b0 || write_reg !== 4 || write_data !== 32'h44) begin
      errors++;
      $display("[TB] FAIL contention_hold actual=%b/%0d/%h required=0/4/44", write_enable, write_reg, write_data);
    end
  endtask

  task automatic test_waw_stall();
    issue_valid = 1'b1;
    issue_reg   = 7;
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL waw_first_issue actual=%b required=1", issue_ready);
    end
    step();
    #1;
    checks++;
    if (issue_ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL waw_stall actual=%b required=0", issue_ready);
    end
    step();
    src1_valid = 1'b1;
    src1_reg   = 7;
    src1_data  = 32'h77;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || src1_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL waw_release actual=%b%b required=11", issue_ready, src1_ready);
    end
    step();
    issue_valid = 1'b0;
    src1_valid  = 1'b0;
    query_reg_a = 7;
    #1;
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL waw_repending actual=%b required=1", busy_a);
    end
    checks++;
    if (write_enable !== 1'b1 || write_reg !== 7 || write_data !== 32'h77) begin
      errors++;
      $display("[TB] FAIL waw_write actual=%b/%0d/%h required=1/7/77", write_enable, write_reg, write_data);
    end
  endtask

  task automatic test_set_clear();
    issue_valid = 1'b1;
    issue_reg   = 3;
    step();
    src0_valid = 1'b1;
    src0_reg   = 3;
    src0_data  = 32'h3333;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || src0_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL setclr_same_cycle actual=%b%b required=11", issue_ready, src0_ready);
    end
    step();
    issue_valid = 1'b0;
    src0_valid  = 1'b0;
    query_reg_b = 3;
    #1;
    checks++;
    if (busy_b !== 1'b1) begin
      errors++;
      $display("[TB] FAIL setclr_busy_r3 actual=%b required=1", busy_b);
    end
  endtask

  task automatic test_mid_reset();
    issue_valid = 1'b1;
    issue_reg   = 9;
    step();
    issue_valid = 1'b0;
    src0_valid  = 1'b1;
    src0_reg    = 9;
    src0_data   = 32'h9999;
    step();
    src0_valid = 1'b0;
    #1;
    checks++;
    if (write_enable !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrst_pre_we actual=%b required=1", write_enable);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (write_enable !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_we actual=%b required=0", write_enable);
    end
    query_reg_a = 7;
    query_reg_b = 3;
    #1;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_busy_7_3 actual=%b%b required=00", busy_a, busy_b);
    end
    query_reg_a = 5;
    query_reg_b = 1;
    #1;
    checks++;
    if (busy_a !== 1'b0 || busy_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midrst_busy_5_1 actual=%b%b required=00", busy_a, busy_b);
    end
    step();
    rst_n = 1'b1;
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    step();
    test_single_source();
    test_contention();
    step();
    test_waw_stall();
    step();
    test_set_clear();
    step();
    test_mid_reset();
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bank_reg_wb_arbiter.md
# cpu_bank_reg_wb_arbiter

Writeback controller for the CPU register bank. It shares the bank's single write port between two writeback sources: source 0 is ALU writeback and source 1 is memory-load writeback. Grants use round-robin, and the winning write is registered onto the bank write port. A per-register pending scoreboard lets decode stall on operands that are still in flight. It sits between the execute/memory stages and the bank register, and drives the bank's `write_reg`, `write_data` and `write_enable`.

## Interface
- `NUM_REGS`, default `` `NUM_REGS ``: number of architectural registers. Register index width is `RW = $clog2(NUM_REGS)`.
- `REG_WIDTH`, default `` `REG_WIDTH ``: data width.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `issue_valid`  in  1  decode issues an instruction that will write `issue_reg`.
- `issue_reg`  in  RW  destination register of the issued instruction.
- `issue_ready`  out  1  issue is accepted this cycle.
- `src0_valid`, `src1_valid`  in  1  writeback request from the source.
- `src0_reg`, `src1_reg`  in  RW  destination register of the request.
- `src0_data`, `src1_data`  in  REG_WIDTH  write data of the request.
- `src0_ready`, `src1_ready`  out  1  grant; the request is consumed at this clock edge.
- `query_reg_a`, `query_reg_b`  in  RW  operand registers being decoded.
- `busy_a`, `busy_b`  out  1  the queried register has a pending write.
- `write_reg`  out  RW  to bank write port.
- `write_data`  out  REG_WIDTH  to bank write port.
- `write_enable`  out  1  to bank write port.

## Operation
- **State held:**
  - `pending[NUM_REGS-1:0]`
  - `last_grant` (1 bit)
  - Output registers `write_reg`, `write_data`, `write_enable`.
- **Reset values:**
  - `pending` = 0.
  - `last_grant` = 1, so source 0 wins the first contention.
  - `write_enable` = 0, `write_reg` = 0, `write_data` = 0.
- **Arbitration (combinational):**
  - Only one valid source: it is granted.
  - Both valid: grant source 0 if `last_grant` = 1, else source 1.
  - Neither valid: no grant.
  - `srcX_ready` = grant to X. At most one ready per cycle.
  - `last_grant` updates to the granted index on every grant; it holds otherwise.
- **Commit:** on a grant, the next edge loads `write_reg`/`write_data` from the winner and sets `write_enable` = 1. With no grant, `write_enable` = 0 and `write_reg`/`write_data` hold.
- **Scoreboard:**
  - `issue_ready = !pending[issue_reg] || (commit_now && commit_reg == issue_reg)`, where `commit_now` and `commit_reg` describe the grant in the same cycle. This guarantees at most one outstanding writer per register (no WAW).
  - Accepted issue (`issue_valid && issue_ready`): `pending[issue_reg]` is set at the edge.
  - Grant: `pending[winner_reg]` is cleared at the edge.
  - Same register set and cleared in the same cycle: the set wins.
- **Busy outputs:** `busy_a = pending[query_reg_a]`, `busy_b = pending[query_reg_b]`, both combinational from the flops.
- **Request rules:**
  - A request that does not match a pending bit is a protocol error. It is still written to the bank; the clear is a no-op.
  - Sources must hold valid, reg and data stable until granted.

## Timing
- Grant is in the same cycle as valid (combinational ready).
- Bank write: a grant at edge N drives `write_enable` high during cycle N+1. The bank captures the data at edge N+2.
- The pending clear is visible (busy drops) in cycle N+1, the same cycle `write_enable` is high. Decode relies on bank write-before-read to read the new value.
- Throughput is one writeback per cycle. A losing source waits at most one cycle when the other source does not re-request.
- Reset asserted mid-operation clears all pending bits and `write_enable` immediately. An in-flight write is dropped, and the sources are flushed by the same reset.

## Structure
- Shared package `cpu_pkg`:
  - `reg_idx_t` (RW bits) and `reg_data_t` (REG_WIDTH bits).
  - Localparam `NUM_WB_SRC = 2`.
- One sub-module, `cpu_rr_arbiter2`: 2-input round-robin grant with the `last_grant` flop.
- The scoreboard and output register stay in the top.

## Test plan
- **Reset:** hold `rst_n` = 0. Expect `write_enable` = 0 and `busy_a` = `busy_b` = 0 for every query. Issue r5 → `issue_ready` = 1, and the next cycle `busy_a` (`query_reg_a` = 5) = 1.
- **Single source:** `src0_valid`, reg 5, data 0xA5A5 → `src0_ready` = 1 in the same cycle. The next cycle has `write_enable` = 1, `write_reg` = 5, `write_data` = 0xA5A5, and `busy` for r5 = 0.
- **Contention:** both sources valid for 4 cycles (regs 1 and 2, then 3 and 4) → grants alternate src0, src1, src0, src1 (starting after reset). `write_enable` stays high for 4 consecutive cycles.
- **WAW stall:** r7 pending, issue r7 with no commit → `issue_ready` = 0. The cycle src1 writes r7, `issue_ready` = 1. Afterwards `pending[7]` = 1.
- **Simultaneous set/clear:** issue r3 accepted while src0 commits r3 → `busy` for r3 = 1 the next cycle.
- **Mid-write reset:** assert `rst_n` = 0 the cycle after a grant → `write_enable` = 0 asynchronously and all `busy` = 0.
